// File: rtl/morse_pkg.sv
// Shared types and timing constants for the ASCII-to-Morse transmitter.
// Codes are {count[2:0], pattern[4:0]}; pattern[count-1] is sent first, 1 = dash.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MARK,
        SPACE,
        GAP
    } state_t;

    localparam logic [7:0] CODE_WORD_GAP        = 8'hE0;

    localparam logic [2:0] DOT_UNITS            = 3'd1;
    localparam logic [2:0] DASH_UNITS           = 3'd3;
    localparam logic [2:0] ELEM_GAP_UNITS       = 3'd1;
    localparam logic [2:0] LETTER_GAP_UNITS     = 3'd3;
    localparam logic [2:0] WORD_GAP_EXTRA_UNITS = 3'd4;

    function automatic logic [2:0] elem_units(input logic dash);
        return dash ? DASH_UNITS : DOT_UNITS;
    endfunction

endpackage

// File: rtl/ascii2morse_rom.sv
// 256x8 synchronous ROM: ASCII character -> {count, pattern} Morse code.
// Lower-case letters fold onto upper-case; anything without a code reads 8'h00.
module ascii2morse_rom (
    input  logic       clk,
    input  logic [7:0] addr,
    output logic [7:0] data
);

    logic [7:0] up;
    logic [7:0] code;

    always_comb begin
        up = ((addr >= 8'h61) && (addr <= 8'h7A)) ? (addr - 8'h20) : addr;
        case (up)
            8'h20: code = 8'hE0;
            8'h30: code = 8'hBF;
            8'h31: code = 8'hAF;
            8'h32: code = 8'hA7;
            8'h33: code = 8'hA3;
            8'h34: code = 8'hA1;
            8'h35: code = 8'hA0;
            8'h36: code = 8'hB0;
            8'h37: code = 8'hB8;
            8'h38: code = 8'hBC;
            8'h39: code = 8'hBE;
            8'h41: code = 8'h41;
            8'h42: code = 8'h88;
            8'h43: code = 8'h8A;
            8'h44: code = 8'h64;
            8'h45: code = 8'h20;
            8'h46: code = 8'h82;
            8'h47: code = 8'h66;
            8'h48: code = 8'h80;
            8'h49: code = 8'h40;
            8'h4A: code = 8'h87;
            8'h4B: code = 8'h65;
            8'h4C: code = 8'h84;
            8'h4D: code = 8'h43;
            8'h4E: code = 8'h42;
            8'h4F: code = 8'h67;
            8'h50: code = 8'h86;
            8'h51: code = 8'h8D;
            8'h52: code = 8'h62;
            8'h53: code = 8'h60;
            8'h54: code = 8'h21;
            8'h55: code = 8'h61;
            8'h56: code = 8'h81;
            8'h57: code = 8'h63;
            8'h58: code = 8'h89;
            8'h59: code = 8'h8B;
            8'h5A: code = 8'h8C;
            default: code = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        data <= code;
    end

endmodule

// File: rtl/morse_encoder.sv
// ASCII-to-Morse transmitter: one character per valid/ready handshake,
// keyed out as dots, dashes and gaps measured in TIMER_FINAL_VALUE+1 cycle units.
module morse_encoder
    import morse_pkg::*;
#(
    parameter int unsigned TIMER_FINAL_VALUE = 9_999_999
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       key,
    output logic       busy,
    output logic       bad_char
);

    localparam int unsigned TW = (TIMER_FINAL_VALUE > 0) ? $clog2(TIMER_FINAL_VALUE + 1) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TIMER_FINAL_VALUE);

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    unit_q, unit_d;
    logic [2:0]    units_q, units_d;
    logic [2:0]    idx_q, idx_d;
    logic [4:0]    pat_q, pat_d;

    logic [7:0]    code;
    logic [2:0]    code_cnt;
    logic [4:0]    code_pat;
    logic [2:0]    idx_dec;
    logic          unit_done;
    logic          elem_done;

    // ROM samples din every cycle, so its output holds the accepted
    // character's code during LOOKUP.
    ascii2morse_rom u_rom (
        .clk  (clk),
        .addr (din),
        .data (code)
    );

    assign code_cnt  = code[7:5];
    assign code_pat  = code[4:0];
    assign idx_dec   = idx_q - 3'd1;
    assign unit_done = (tick_q == TICK_LAST);
    assign elem_done = unit_done && (unit_q == units_q - 3'd1);

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        unit_d    = unit_q;
        units_d   = units_q;
        idx_d     = idx_q;
        pat_d     = pat_q;
        din_ready = 1'b0;
        key       = 1'b0;
        busy      = 1'b1;
        bad_char  = 1'b0;

        if ((state_q == MARK) || (state_q == SPACE) || (state_q == GAP)) begin
            if (unit_done) begin
                tick_d = '0;
                unit_d = unit_q + 3'd1;
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                busy      = 1'b0;
                din_ready = ~reset;
                if (din_valid) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (code == CODE_WORD_GAP) begin
                    // Letter gap already sent by the previous character: 3 + 4 = 7 units.
                    state_d = GAP;
                    units_d = WORD_GAP_EXTRA_UNITS;
                end else if ((code_cnt == 3'd0) || (code_cnt > 3'd5)) begin
                    bad_char = 1'b1;
                    state_d  = IDLE;
                end else begin
                    pat_d   = code_pat;
                    idx_d   = code_cnt - 3'd1;
                    units_d = elem_units(code_pat[code_cnt - 3'd1]);
                    state_d = MARK;
                end
            end
            MARK: begin
                key = 1'b1;
                if (elem_done) begin
                    if (idx_q == 3'd0) begin
                        state_d = GAP;
                        units_d = LETTER_GAP_UNITS;
                    end else begin
                        state_d = SPACE;
                        units_d = ELEM_GAP_UNITS;
                    end
                end
            end
            SPACE: begin
                if (elem_done) begin
                    idx_d   = idx_dec;
                    units_d = elem_units(pat_q[idx_dec]);
                    state_d = MARK;
                end
            end
            GAP: begin
                if (elem_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Every transition changes state, so restarting the timer here
        // gives each element an exact units x U duration.
        if (state_d != state_q) begin
            tick_d = '0;
            unit_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            unit_q  <= '0;
            units_q <= '0;
            idx_q   <= '0;
            pat_q   <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            unit_q  <= unit_d;
            units_q <= units_d;
            idx_q   <= idx_d;
            pat_q   <= pat_d;
        end
    end

endmodule

// File: tb/tb_morse_encoder.sv
// Scoreboard bench for morse_encoder with U = 4 cycles: each accepted character
// queues its expected per-cycle {key, busy, din_ready, bad_char} trace.
module tb_morse_encoder;

    localparam int unsigned TFV = 3;
    localparam int          U   = TFV + 1;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic [7:0] din       = 8'h45;
    logic       din_valid = 1'b1;
    logic       din_ready, key, busy, bad_char;

    int checks = 0;
    int passes = 0;
    logic [3:0] exp_q [$];

    morse_encoder #(.TIMER_FINAL_VALUE(TFV)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .key       (key),
        .busy      (busy),
        .bad_char  (bad_char)
    );

    always #5 clk = ~clk;

    // Expected trace from the cycle after the handshake up to and including
    // the first cycle back in IDLE.
    task automatic push_code(input logic [7:0] code);
        int cnt;
        logic [4:0] pat;
        cnt = int'(code[7:5]);
        pat = code[4:0];
        if (code == 8'hE0) begin
            exp_q.push_back(4'b0100);
            repeat (4 * U) exp_q.push_back(4'b0100);
        end else if (cnt == 0 || cnt > 5) begin
            exp_q.push_back(4'b0101);
        end else begin
            exp_q.push_back(4'b0100);
            for (int i = cnt - 1; i >= 0; i--) begin
                repeat ((pat[i] ? 3 : 1) * U) exp_q.push_back(4'b1100);
                if (i > 0) repeat (U) exp_q.push_back(4'b0100);
            end
            repeat (3 * U) exp_q.push_back(4'b0100);
        end
        exp_q.push_back(4'b0010);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({key, busy, din_ready} !== 3'b000)
                $display("FAIL reset_hold cycle %0d: {key,busy,rdy} got %b want 000", k, {key, busy, din_ready});
            else passes++;
        end
        reset = 1'b0;
        din_valid = 1'b0;
        #1;
        checks++;
        if ({key, busy, din_ready} !== 3'b001)
            $display("FAIL reset_release: {key,busy,rdy} got %b want 001", {key, busy, din_ready});
        else passes++;
    endtask

    task automatic test_single();
        logic [7:0] chs [5];
        logic [7:0] cds [5];
        logic [3:0] e, o;
        chs = '{8'h45, 8'h41, 8'h6B, 8'h39, 8'h51};
        cds = '{8'h20, 8'h41, 8'h65, 8'hBE, 8'h8D};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            din = chs[k];
            din_valid = 1'b1;
            push_code(cds[k]);
            for (int cyc = 1; exp_q.size() > 0; cyc++) begin
                @(negedge clk);
                din_valid = 1'b0;
                e = exp_q.pop_front();
                o = {key, busy, din_ready, bad_char};
                checks++;
                if (o !== e)
                    $display("FAIL single 0x%h c+%0d: {key,busy,rdy,bad} got %b want %b", chs[k], cyc, o, e);
                else passes++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] chs [3];
        logic [7:0] cds [3];
        logic [3:0] e, o;
        int run, last_run;
        chs = '{8'h53, 8'h20, 8'h54};
        cds = '{8'h60, 8'hE0, 8'h21};
        run = 0;
        last_run = -1;
        @(negedge clk);
        din_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            din = chs[k];
            push_code(cds[k]);
            for (int cyc = 1; exp_q.size() > 0; cyc++) begin
                @(negedge clk);
                e = exp_q.pop_front();
                o = {key, busy, din_ready, bad_char};
                if (key === 1'b0) run++;
                else if (run > 0) begin
                    last_run = run;
                    run = 0;
                end
                checks++;
                if (o !== e)
                    $display("FAIL b2b 0x%h c+%0d: {key,busy,rdy,bad} got %b want %b", chs[k], cyc, o, e);
                else passes++;
            end
        end
        din_valid = 1'b0;
        checks++;
        if (last_run !== 32)
            $display("FAIL b2b_word_gap: low run got %0d want 32", last_run);
        else passes++;
    endtask

    task automatic test_bad_char();
        logic [7:0] chs [2];
        logic [3:0] e, o;
        chs = '{8'h23, 8'h7E};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            din = chs[k];
            din_valid = 1'b1;
            push_code(8'h00);
            for (int cyc = 1; exp_q.size() > 0; cyc++) begin
                @(negedge clk);
                din_valid = 1'b0;
                e = exp_q.pop_front();
                o = {key, busy, din_ready, bad_char};
                checks++;
                if (o !== e)
                    $display("FAIL bad_char 0x%h c+%0d: {key,busy,rdy,bad} got %b want %b", chs[k], cyc, o, e);
                else passes++;
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [3:0] e, o;
        @(negedge clk);
        din = 8'h30;
        din_valid = 1'b1;
        push_code(8'hBF);
        // c+23 is the 6th cycle of the second dash.
        for (int cyc = 1; cyc <= 23; cyc++) begin
            @(negedge clk);
            din_valid = 1'b0;
            e = exp_q.pop_front();
            o = {key, busy, din_ready, bad_char};
            checks++;
            if (o !== e)
                $display("FAIL abort_pre c+%0d: {key,busy,rdy,bad} got %b want %b", cyc, o, e);
            else passes++;
        end
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if ({key, busy, din_ready} !== 3'b000)
            $display("FAIL abort_reset: {key,busy,rdy} got %b want 000", {key, busy, din_ready});
        else passes++;
        reset = 1'b0;
        #1;
        checks++;
        if ({key, busy, din_ready} !== 3'b001)
            $display("FAIL abort_release: {key,busy,rdy} got %b want 001", {key, busy, din_ready});
        else passes++;
        din = 8'h45;
        din_valid = 1'b1;
        push_code(8'h20);
        for (int cyc = 1; exp_q.size() > 0; cyc++) begin
            @(negedge clk);
            din_valid = 1'b0;
            e = exp_q.pop_front();
            o = {key, busy, din_ready, bad_char};
            checks++;
            if (o !== e)
                $display("FAIL abort_then_E c+%0d: {key,busy,rdy,bad} got %b want %b", cyc, o, e);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_bad_char();
        test_reset_abort();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
